ddr2idx_loader: RTL
===================

# ddr2idx_loader

Parametrised DDR-to-index-buffer loader. Unpacks a stream of DDR words into index pairs and writes them into the per-PE index buffers. Adds over the previous generation:
- a real valid/ready handshake;
- a start/done FSM with an exact index count;
- a base address;
- partial-last-word handling;
- an optional round-robin PE distribution mode.

It sits between the DDR read stream and the PE index buffers, driven by the layer controller.

## Interface
- DDR_W, 512, DDR data width; multiple of 2*IDX_W
- IDX_W, 16, width of one index; one buffer entry is 2*IDX_W
- IDX_DEPTH, 256, index buffer depth; power of 2
- ADDR_W, bw(IDX_DEPTH), buffer address width
- PE_NUM, 32, number of PEs; power of 2
- IDX_BATCH (local), DDR_W/(2*IDX_W), index pairs per DDR word
---
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a transfer, sampled only in IDLE
- done  out  1  one-cycle pulse when the transfer completes
- conf_mode  in  4  [2:1]==2'b01 swaps the two IDX_W halves; [3] selects round-robin (only with macro)
- conf_idx_num  in  ADDR_W+1  number of index pairs to load (0..IDX_DEPTH)
- conf_base_addr  in  ADDR_W  first buffer address
- conf_mask  in  PE_NUM  PE write mask
- ddr_data  in  DDR_W  DDR word; lane 0 = bits [2*IDX_W-1:0]
- ddr_valid  in  1  DDR word valid
- ddr_ready  out  1  loader accepts a word; a transfer happens on ddr_valid & ddr_ready
- idx_wr_data  out  2*IDX_W  index pair write data
- idx_wr_addr  out  ADDR_W  write address
- idx_wr_en  out  PE_NUM  per-PE write enable

## Operation
- conf_* are latched on the start pulse. They are ignored afterwards until the block returns to IDLE.
- FSM states:
  - IDLE
  - FETCH
  - UNPACK
  - DONE
- IDLE:
  - start with conf_idx_num==0 -> DONE.
  - start with conf_idx_num!=0 -> FETCH.
  - start in any other state is ignored.
- FETCH:
  - ddr_ready=1.
  - On a handshake, capture the word, set lane=0 and go to UNPACK.
- UNPACK:
  - Emit one index pair per cycle: lane `lane` of the captured word.
  - lane increments; the internal pair counter cnt increments.
  - When cnt reaches conf_idx_num-1 on the current pair -> DONE. Remaining lanes of the word are discarded.
  - When lane==IDX_BATCH-1 and pairs remain, ddr_ready=1. A handshake in that cycle recaptures the word, sets lane=0 and stays in UNPACK, giving a sustained rate of one pair per cycle.
  - With no handshake in that cycle -> FETCH.
- DONE: assert done for one cycle, then go to IDLE.
- Data selection:
  - With swap mode, pair = {lane[IDX_W-1:0], lane[2*IDX_W-1:IDX_W]}.
  - Otherwise the lane passes unchanged.
- Broadcast mode (default):
  - idx_wr_en = conf_mask.
  - idx_wr_addr = conf_base_addr + cnt, modulo IDX_DEPTH (wraps).
- ddr_valid without ddr_ready: the word is not consumed. The upstream holds its data.
- rst in any state:
  - next cycle is IDLE;
  - all counters cleared;
  - any partial transfer is abandoned without a done pulse.

## Timing
- Reset values:
  - ddr_ready=0, done=0;
  - idx_wr_en=0, idx_wr_addr=0, idx_wr_data=0.
- ddr_ready is driven combinationally from state/lane/cnt. It does not depend on ddr_valid.
- idx_wr_* are registered; idx_wr_en is nonzero only in a write cycle.
- Handshake at edge E -> lane 0 is written in the cycle following edge E+1. Lane k is written in the cycle following edge E+1+k.
- First write follows start by at least 2 cycles.
- done is asserted in the cycle after the last write cycle.
- conf_idx_num==0: done is asserted 2 cycles after start; no write and no ddr_ready.

## Configuration
- DDR2IDX_RR_EN defined:
  - conf_mode[3]=1 selects round-robin.
  - Pair cnt goes to PE p = cnt mod PE_NUM: idx_wr_en = conf_mask & (1<<p).
  - idx_wr_addr = conf_base_addr + (cnt >> log2(PE_NUM)), modulo IDX_DEPTH.
  - A masked-off PE still consumes its slot; the write is suppressed.
- DDR2IDX_RR_EN undefined:
  - conf_mode[3] is ignored; broadcast always applies.
  - No round-robin logic is synthesised.

## Test plan
With DDR_W=512, IDX_W=16 (IDX_BATCH=16) and PE_NUM=32:
- Full load: conf_idx_num=32, base=0, mask=all-ones, ddr_valid held high.
  - Expect 2 handshakes and 32 consecutive writes at addresses 0..31, data = lanes in order.
  - Expect done 1 cycle after the last write.
- Partial word: conf_idx_num=20.
  - Expect the second word's lanes 4..15 never written.
  - Expect exactly 20 writes.
  - Expect ddr_ready low after the second handshake.
- Backpressure: ddr_valid toggling with a 1-cycle gap.
  - Expect no lost or duplicated pairs and write addresses contiguous.
  - Expect writes to stall while in FETCH.
- Swap and wrap: conf_mode=4'b0010, base=250, num=10, lane0=32'hAAAA_5555.
  - Expect the first write data = 32'h5555_AAAA.
  - Expect addresses 250..255 then 0..3.
- Zero count and reset:
  - num=0: expect done 2 cycles after start and no ddr_ready.
  - rst mid-UNPACK: expect IDLE next cycle, outputs 0, no done pulse.
- With DDR2IDX_RR_EN, conf_mode[3]=1, num=64, mask=32'h0000_FFFF:
  - pair 5 -> en=32'h20 at addr=base+0;
  - pair 37 -> en=32'h20 at addr=base+1;
  - pair 20 -> en=0.

Source files
------------

// File: rtl/ddr2idx_loader_if.sv
// ddr2idx_loader_if: DDR read stream and PE index-buffer write bus of the loader
interface ddr2idx_loader_if #(
    parameter int DDR_W  = 512,
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 8,
    parameter int PE_NUM = 32
);
    logic [DDR_W-1:0]   ddr_data;
    logic               ddr_valid;
    logic               ddr_ready;
    logic [2*IDX_W-1:0] idx_wr_data;
    logic [ADDR_W-1:0]  idx_wr_addr;
    logic [PE_NUM-1:0]  idx_wr_en;
    modport master (output ddr_data, ddr_valid, input ddr_ready, idx_wr_data, idx_wr_addr, idx_wr_en);
    modport slave (input ddr_data, ddr_valid, output ddr_ready, idx_wr_data, idx_wr_addr, idx_wr_en);
endinterface

// File: rtl/ddr2idx_loader.sv
// ddr2idx_loader: unpacks DDR words into index pairs for the PE index buffers; DDR2IDX_RR_EN adds round-robin PE distribution
module ddr2idx_loader #(
    parameter int DDR_W     = 512,
    parameter int IDX_W     = 16,
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = $clog2(IDX_DEPTH),
    parameter int PE_NUM    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [3:0]        conf_mode,
    input  logic [ADDR_W:0]   conf_idx_num,
    input  logic [ADDR_W-1:0] conf_base_addr,
    input  logic [PE_NUM-1:0] conf_mask,
    ddr2idx_loader_if.slave   bus
);
    localparam int PAIR_W    = 2 * IDX_W;
    localparam int IDX_BATCH = DDR_W / PAIR_W;
    localparam int LANE_W    = IDX_BATCH > 1 ? $clog2(IDX_BATCH) : 1;
`ifdef DDR2IDX_RR_EN
    localparam int PE_W      = $clog2(PE_NUM);
`endif
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, UNPACK = 2'd2, DONE = 2'd3;

    logic [1:0]                       state_q, state_d;
    logic [LANE_W-1:0]                lane_q, lane_d;
    logic [ADDR_W:0]                  cnt_q, cnt_d;
    logic [IDX_BATCH-1:0][PAIR_W-1:0] word_q, word_d;
    logic                             swap_q, swap_d;
    logic [ADDR_W:0]                  num_q, num_d;
    logic [ADDR_W-1:0]                base_q, base_d;
    logic [PE_NUM-1:0]                mask_q, mask_d;
    logic                             done_q, done_d;
    logic [PAIR_W-1:0]                data_q, data_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [PE_NUM-1:0]                en_q, en_d;
`ifdef DDR2IDX_RR_EN
    logic                             rr_q, rr_d;
`endif
    logic                             last, lane_end, hs, unused_mode;
    logic [PAIR_W-1:0]                pair;

    assign unused_mode   = ^{conf_mode[3], conf_mode[0]};
    assign last          = cnt_q == num_q - 1'b1;
    assign lane_end      = lane_q == LANE_W'(IDX_BATCH - 1);
    assign bus.ddr_ready = state_q == FETCH || (state_q == UNPACK && lane_end && !last);
    assign hs            = bus.ddr_ready && bus.ddr_valid;
    assign pair          = swap_q ? {word_q[lane_q][IDX_W-1:0], word_q[lane_q][PAIR_W-1:IDX_W]} : word_q[lane_q];
    assign done            = done_q;
    assign bus.idx_wr_data = data_q;
    assign bus.idx_wr_addr = addr_q;
    assign bus.idx_wr_en   = en_q;

    // transfer sequencing: latch config on start, fetch words, walk lanes until the pair count is reached
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        swap_d  = swap_q;
        num_d   = num_q;
        base_d  = base_q;
        mask_d  = mask_q;
`ifdef DDR2IDX_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = conf_idx_num == '0 ? DONE : FETCH;
                cnt_d   = '0;
                swap_d  = conf_mode[2:1] == 2'b01;
                num_d   = conf_idx_num;
                base_d  = conf_base_addr;
                mask_d  = conf_mask;
`ifdef DDR2IDX_RR_EN
                rr_d    = conf_mode[3];
`endif
            end
            FETCH: if (hs) begin
                state_d = UNPACK;
                word_d  = bus.ddr_data;
                lane_d  = '0;
            end
            UNPACK: begin
                cnt_d   = cnt_q + 1'b1;
                lane_d  = hs ? '0 : lane_q + 1'b1;
                word_d  = hs ? bus.ddr_data : word_q;
                state_d = last ? DONE : (lane_end && !hs) ? FETCH : UNPACK;
            end
            default: state_d = IDLE;
        endcase
    end

    // registered write port and done pulse; every UNPACK cycle is a write slot
    always_comb begin
        done_d = state_q == DONE;
        data_d = '0;
        addr_d = '0;
        en_d   = '0;
        if (state_q == UNPACK) begin
            data_d = pair;
`ifdef DDR2IDX_RR_EN
            en_d   = rr_q ? mask_q & (PE_NUM'(1) << (cnt_q & (ADDR_W+1)'(PE_NUM - 1))) : mask_q;
            addr_d = base_q + (rr_q ? ADDR_W'(cnt_q >> PE_W) : cnt_q[ADDR_W-1:0]);
`else
            en_d   = mask_q;
            addr_d = base_q + cnt_q[ADDR_W-1:0];
`endif
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            swap_q  <= 1'b0;
            num_q   <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            en_q    <= '0;
`ifdef DDR2IDX_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            swap_q  <= swap_d;
            num_q   <= num_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
`ifdef DDR2IDX_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end
endmodule
